// File: rtl/pmod_cls_spi_responder_pkg.sv
// Shared types, ASCII constants and byte-class helpers for the PMOD CLS SPI responder.
// The error counter is built only when PMOD_CLS_RESPONDER_ERR_COUNT_EN is defined.
package pmod_stand_spi_solo_pkg;

  // Element [i] holds the character shown in column i.
  typedef logic [15:0][7:0] t_pmod_cls_ascii_line_16;

  typedef enum logic [2:0] {
    ST_TEXT,
    ST_ESC,
    ST_CSI,
    ST_ROW,
    ST_COL
  } t_pmod_cls_resp_state;

  localparam logic [7:0] c_ascii_esc    = 8'h1B;
  localparam logic [7:0] c_ascii_lbrack = 8'h5B;
  localparam logic [7:0] c_ascii_semi   = 8'h3B;
  localparam logic [7:0] c_ascii_H      = 8'h48;
  localparam logic [7:0] c_ascii_j      = 8'h6A;
  localparam logic [7:0] c_ascii_space  = 8'h20;

  localparam t_pmod_cls_ascii_line_16 c_blank_line = {16{c_ascii_space}};
  localparam logic [6:0] c_acc_max = 7'd99;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

  // Decimal accumulate acc*10 + digit, saturating at 99.
  function automatic logic [6:0] acc_step(input logic [6:0] acc, input logic [7:0] b);
    logic [10:0] sum;
    sum = 11'(acc) * 11'd10 + 11'(b - 8'h30);
    return (sum > 11'(c_acc_max)) ? c_acc_max : sum[6:0];
  endfunction

endpackage

// File: rtl/pmod_cls_spi_responder_if.sv
// SPI pins between the CLS driver (master) and the display responder (slave).
interface pmod_cls_spi_responder_if;
  logic ei_sck;
  logic ei_csn;
  logic ei_copi;
  logic eo_cipo_o;
  logic eo_cipo_t;

  modport master (output ei_sck, ei_csn, ei_copi, input eo_cipo_o, eo_cipo_t);
  modport slave  (input ei_sck, ei_csn, ei_copi, output eo_cipo_o, eo_cipo_t);
endinterface

// File: rtl/pmod_cls_spi_responder_shifter.sv
// Synchronizes the raw SPI pins, detects SCK rising edges and assembles MSB-first bytes.
// byte_valid is a one-cycle strobe with no ready: the consumer must take byte_data that cycle.
module pmod_spi_responder_shifter #(
  parameter int parm_sync_stages = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sck,
  input  logic       csn,
  input  logic       copi,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       partial_abort
);

  logic [parm_sync_stages-1:0] sck_sync, csn_sync, copi_sync;
  logic sck_q, sck_d, csn_q, csn_d, copi_q;
  logic [6:0] shreg;
  logic [2:0] cnt;
  logic shift_en;

  // CSN is taken from either of the two aligned samples so a CSN rise that
  // coincides with the final SCK edge still completes the byte.
  assign shift_en = sck_q && !sck_d && (!csn_q || !csn_d);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sck_sync      <= '0;
      csn_sync      <= '1;
      copi_sync     <= '0;
      sck_q         <= 1'b0;
      sck_d         <= 1'b0;
      csn_q         <= 1'b1;
      csn_d         <= 1'b1;
      copi_q        <= 1'b0;
      shreg         <= '0;
      cnt           <= '0;
      byte_valid    <= 1'b0;
      byte_data     <= '0;
      partial_abort <= 1'b0;
    end else begin
      sck_sync      <= {sck_sync[parm_sync_stages-2:0], sck};
      csn_sync      <= {csn_sync[parm_sync_stages-2:0], csn};
      copi_sync     <= {copi_sync[parm_sync_stages-2:0], copi};
      sck_q         <= sck_sync[parm_sync_stages-1];
      csn_q         <= csn_sync[parm_sync_stages-1];
      copi_q        <= copi_sync[parm_sync_stages-1];
      sck_d         <= sck_q;
      csn_d         <= csn_q;
      byte_valid    <= 1'b0;
      partial_abort <= 1'b0;
      if (shift_en) begin
        shreg <= {shreg[5:0], copi_q};
        cnt   <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          byte_data  <= {shreg, copi_q};
          byte_valid <= 1'b1;
        end
      end else if (csn_q) begin
        cnt           <= '0;
        partial_abort <= (cnt != 3'd0);
      end
    end
  end

endmodule

// File: rtl/pmod_cls_spi_responder.sv
// PMOD CLS display emulator: escape-sequence parser and two 16-char line buffers.
// Define PMOD_CLS_RESPONDER_ERR_COUNT_EN to build the saturating protocol error counter.
module pmod_cls_spi_responder
  import pmod_stand_spi_solo_pkg::*;
#(
  parameter int parm_sync_stages = 2,
  parameter int parm_line_len    = 16
) (
  input  logic                    i_clk_20mhz,
  input  logic                    i_rstn_20mhz,
  pmod_cls_spi_responder_if.slave spi,
  output logic                    o_byte_valid,
  output logic [7:0]              o_byte_data,
  output logic                    o_cmd_clear,
  output logic                    o_line_updated,
  output logic                    o_cursor_row,
  output logic [4:0]              o_cursor_col,
  output t_pmod_cls_ascii_line_16 o_line1,
  output t_pmod_cls_ascii_line_16 o_line2,
  output logic [7:0]              o_err_count,
  output t_pmod_cls_resp_state    o_parser_state
);

  localparam logic [4:0] c_len  = 5'(parm_line_len);
  localparam logic [6:0] c_len7 = 7'(parm_line_len);

  logic byte_valid, partial_abort;
  logic [7:0] byte_data;

  t_pmod_cls_resp_state state_q, state_d;
  t_pmod_cls_ascii_line_16 [1:0] line_q, line_d;
  logic row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [6:0] row_acc_q, row_acc_d, col_acc_q, col_acc_d;
  logic clear_q, clear_d, upd_q, upd_d, err_d;

  assign spi.eo_cipo_o = 1'b0;
  assign spi.eo_cipo_t = 1'b1;

  pmod_spi_responder_shifter #(.parm_sync_stages(parm_sync_stages)) u_shifter (
    .clk           (i_clk_20mhz),
    .rstn          (i_rstn_20mhz),
    .sck           (spi.ei_sck),
    .csn           (spi.ei_csn),
    .copi          (spi.ei_copi),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .partial_abort (partial_abort)
  );

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q   <= ST_TEXT;
      line_q    <= {2{c_blank_line}};
      row_q     <= 1'b0;
      col_q     <= '0;
      row_acc_q <= '0;
      col_acc_q <= '0;
      clear_q   <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      row_q     <= row_d;
      col_q     <= col_d;
      row_acc_q <= row_acc_d;
      col_acc_q <= col_acc_d;
      clear_q   <= clear_d;
      upd_q     <= upd_d;
    end
  end

  // Every byte leaves the parser in ST_TEXT unless a branch says otherwise.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    row_d     = row_q;
    col_d     = col_q;
    row_acc_d = row_acc_q;
    col_acc_d = col_acc_q;
    clear_d   = 1'b0;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    if (byte_valid) begin
      state_d = ST_TEXT;
      unique case (state_q)
        ST_TEXT: begin
          if (byte_data == c_ascii_esc) begin
            state_d = ST_ESC;
          end else if (is_print(byte_data) && (col_q < c_len)) begin
            line_d[row_q][col_q[3:0]] = byte_data;
            col_d = col_q + 5'd1;
            upd_d = 1'b1;
          end
        end
        ST_ESC: begin
          if (byte_data == c_ascii_lbrack) begin
            state_d   = ST_CSI;
            row_acc_d = '0;
            col_acc_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_CSI: begin
          if (byte_data == c_ascii_j) begin
            line_d  = {2{c_blank_line}};
            row_d   = 1'b0;
            col_d   = '0;
            clear_d = 1'b1;
            upd_d   = 1'b1;
          end else if (is_digit(byte_data)) begin
            row_acc_d = acc_step(7'd0, byte_data);
            state_d   = ST_ROW;
          end else if (!is_final(byte_data)) begin
            err_d = 1'b1;
          end
        end
        ST_ROW: begin
          if (is_digit(byte_data)) begin
            row_acc_d = acc_step(row_acc_q, byte_data);
            state_d   = ST_ROW;
          end else if (byte_data == c_ascii_semi) begin
            state_d = ST_COL;
          end else if (byte_data == c_ascii_H) begin
            if (row_acc_q >= 7'd2) begin
              err_d = 1'b1;
            end else begin
              row_d = row_acc_q[0];
              col_d = '0;
            end
          end else if (!is_final(byte_data)) begin
            err_d = 1'b1;
          end
        end
        ST_COL: begin
          if (is_digit(byte_data)) begin
            col_acc_d = acc_step(col_acc_q, byte_data);
            state_d   = ST_COL;
          end else if (byte_data == c_ascii_H) begin
            if (row_acc_q >= 7'd2) begin
              err_d = 1'b1;
            end else begin
              row_d = row_acc_q[0];
              col_d = (col_acc_q > c_len7) ? c_len : col_acc_q[4:0];
            end
          end else if (!is_final(byte_data)) begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_TEXT;
      endcase
    end
  end

`ifdef PMOD_CLS_RESPONDER_ERR_COUNT_EN
  logic [7:0] err_q;
  logic [8:0] err_sum;
  assign err_sum = {1'b0, err_q} + 9'(err_d) + 9'(partial_abort);
  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      err_q <= '0;
    end else begin
      err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
  assign o_err_count = err_q;
`else
  logic unused_err;
  assign unused_err  = err_d ^ partial_abort;
  assign o_err_count = '0;
`endif

  assign o_byte_valid   = byte_valid;
  assign o_byte_data    = byte_data;
  assign o_cmd_clear    = clear_q;
  assign o_line_updated = upd_q;
  assign o_cursor_row   = row_q;
  assign o_cursor_col   = col_q;
  assign o_line1        = line_q[0];
  assign o_line2        = line_q[1];
  assign o_parser_state = state_q;

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Bench for pmod_cls_spi_responder: directed and random CLS traffic against a command-level display model.
`define CHK(tag, obs, exp) \
  begin \
    compared++; \
    assert ((obs) === (exp)) else begin \
      mismatched++; \
      $error("FAIL %s: observed %0h required %0h", tag, (obs), (exp)); \
    end \
  end

module tb_pmod_cls_spi_responder;
  import pmod_stand_spi_solo_pkg::*;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pmod_cls_spi_responder_if spi_if ();

  logic o_byte_valid, o_cmd_clear, o_line_updated, o_cursor_row;
  logic [7:0] o_byte_data, o_err_count;
  logic [4:0] o_cursor_col;
  t_pmod_cls_ascii_line_16 o_line1, o_line2;
  t_pmod_cls_resp_state parser_state;

  pmod_cls_spi_responder #(.parm_sync_stages(SYNC), .parm_line_len(16)) dut (
    .i_clk_20mhz    (clk),
    .i_rstn_20mhz   (rstn),
    .spi            (spi_if),
    .o_byte_valid   (o_byte_valid),
    .o_byte_data    (o_byte_data),
    .o_cmd_clear    (o_cmd_clear),
    .o_line_updated (o_line_updated),
    .o_cursor_row   (o_cursor_row),
    .o_cursor_col   (o_cursor_col),
    .o_line1        (o_line1),
    .o_line2        (o_line2),
    .o_err_count    (o_err_count),
    .o_parser_state (parser_state)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int clear_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  // Display model: what a CLS screen shows after each whole command.
  logic [7:0] m_line[2][16];
  int m_row, m_col, m_err, m_clears;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_byte_valid) begin
      `CHK("byte_expected", (exp_q.size() > 0), 1'b1)
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        `CHK("byte_data", o_byte_data, exp_b)
        `CHK("byte_latency", cyc - last_rise_cyc, SYNC + 2)
      end
    end
    if (o_cmd_clear) begin
      clear_seen++;
      `CHK("clear_line_upd", o_line_updated, 1'b1)
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  function automatic void m_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) m_line[r][c] = 8'h20;
    m_row = 0;
    m_col = 0;
    m_err = 0;
  endfunction

  function automatic void m_clear();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) m_line[r][c] = 8'h20;
    m_row = 0;
    m_col = 0;
    m_clears++;
  endfunction

  function automatic void m_text_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E && m_col < 16) begin
      m_line[m_row][m_col] = b;
      m_col++;
    end
  endfunction

  function automatic void m_goto(input int r, input int c);
    if (r >= 2) m_err++;
    else begin
      m_row = r;
      m_col = (c > 16) ? 16 : c;
    end
  endfunction

  function automatic t_pmod_cls_ascii_line_16 m_pack(input int r);
    t_pmod_cls_ascii_line_16 v;
    for (int i = 0; i < 16; i++) v[i] = m_line[r][i];
    return v;
  endfunction

  function automatic logic [7:0] m_err_exp();
`ifdef PMOD_CLS_RESPONDER_ERR_COUNT_EN
    return (m_err > 255) ? 8'd255 : 8'(m_err);
`else
    return 8'd0;
`endif
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_if.ei_copi = b[i];
      wait_clk(4);
      spi_if.ei_sck = 1'b1;
      if (i == 0) last_rise_cyc = cyc;
      wait_clk(4);
      spi_if.ei_sck = 1'b0;
    end
  endtask

  task automatic tx_begin();
    spi_if.ei_csn = 1'b0;
    wait_clk(4);
  endtask

  task automatic tx_end();
    wait_clk(4);
    spi_if.ei_csn = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    spi_bits(b, 8);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic tx_text(input string s);
    tx_begin();
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      m_text_byte(s[i]);
    end
    tx_end();
  endtask

  task automatic tx_goto(input int r, input int c);
    tx_begin();
    send_byte(8'h1B);
    send_str($sformatf("[%0d;%0dH", r, c));
    tx_end();
    m_goto(r, c);
  endtask

  task automatic tx_clear();
    tx_begin();
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_byte(8'h6A);
    tx_end();
    m_clear();
  endtask

  task automatic check_all(input string tag);
    wait_clk(6);
    `CHK({tag, ".line1"}, o_line1, m_pack(0))
    `CHK({tag, ".line2"}, o_line2, m_pack(1))
    `CHK({tag, ".row"}, o_cursor_row, 1'(m_row))
    `CHK({tag, ".col"}, o_cursor_col, 5'(m_col))
    `CHK({tag, ".err"}, o_err_count, m_err_exp())
    `CHK({tag, ".clears"}, clear_seen, m_clears)
    `CHK({tag, ".pending"}, exp_q.size(), 0)
  endtask

  task automatic check_reset_vals(input string tag);
    `CHK({tag, ".line1"}, o_line1, c_blank_line)
    `CHK({tag, ".line2"}, o_line2, c_blank_line)
    `CHK({tag, ".row"}, o_cursor_row, 1'b0)
    `CHK({tag, ".col"}, o_cursor_col, 5'd0)
    `CHK({tag, ".byte_data"}, o_byte_data, 8'h00)
    `CHK({tag, ".byte_valid"}, o_byte_valid, 1'b0)
    `CHK({tag, ".cmd_clear"}, o_cmd_clear, 1'b0)
    `CHK({tag, ".line_upd"}, o_line_updated, 1'b0)
    `CHK({tag, ".err"}, o_err_count, 8'h00)
    `CHK({tag, ".cipo_o"}, spi_if.eo_cipo_o, 1'b0)
    `CHK({tag, ".cipo_t"}, spi_if.eo_cipo_t, 1'b1)
  endtask

  initial begin
    int op, n, r, c;
    logic [7:0] b;
    string s;

    spi_if.ei_sck  = 1'b0;
    spi_if.ei_csn  = 1'b1;
    spi_if.ei_copi = 1'b0;
    m_clears = 0;
    m_reset();
    rstn = 1'b0;
    wait_clk(5);
    rstn = 1'b1;
    wait_clk(2);
    check_reset_vals("reset");

    // Preload text, then clear.
    tx_text("HELLO");
    check_all("preload");
    tx_clear();
    check_all("clear");

    tx_goto(0, 0);
    tx_text("ACL TESTER");
    check_all("line1_text");

    tx_goto(1, 0);
    tx_text("ABCDEFGHIJKLMNOPQRST");
    check_all("line2_sat");

    // Five-bit fragment then a full byte.
    tx_begin();
    spi_bits(8'hA5, 5);
    tx_end();
    m_err++;
    tx_text("A");
    `CHK("frag_byte", o_byte_data, 8'h41)
    check_all("fragment");

    // Bad escape, then an out-of-range row.
    tx_begin();
    send_byte(8'h1B);
    send_byte(8'h58);
    tx_end();
    m_err++;
    tx_goto(2, 0);
    check_all("bad_esc_row");

    // Unsupported finals are silently ignored.
    tx_begin();
    send_byte(8'h1B);
    send_str("[K");
    send_byte(8'h1B);
    send_str("[0h");
    tx_end();
    check_all("unsupported");

    // Column saturation above the line length, then a command split over two transactions.
    tx_goto(0, 45);
    tx_text("Q");
    check_all("col_sat");
    tx_begin();
    send_byte(8'h1B);
    tx_end();
    tx_begin();
    send_str("[0;5H");
    tx_end();
    m_goto(0, 5);
    tx_text("xy");
    check_all("span");

    // CSN rises together with the 8th SCK edge.
    tx_goto(1, 3);
    tx_begin();
    spi_bits(8'h5A, 7);
    spi_if.ei_copi = 1'b0;
    wait_clk(4);
    exp_q.push_back(8'h5A);
    spi_if.ei_sck = 1'b1;
    spi_if.ei_csn = 1'b1;
    last_rise_cyc = cyc;
    wait_clk(4);
    spi_if.ei_sck = 1'b0;
    wait_clk(8);
    m_text_byte(8'h5A);
    check_all("csn_with_edge");

    for (int it = 0; it < 25; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 1, 2: begin
          n = $urandom_range(1, 6);
          tx_begin();
          for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 7) == 0) begin
              b = 8'($urandom_range(0, 31));
              if (b == 8'h1B) b = 8'h0A;
            end else begin
              b = 8'($urandom_range(32, 126));
            end
            send_byte(b);
            m_text_byte(b);
          end
          tx_end();
        end
        3: tx_goto($urandom_range(0, 2), $urandom_range(0, 25));
        4: begin
          r = $urandom_range(0, 3);
          tx_begin();
          send_byte(8'h1B);
          send_str($sformatf("[%0dH", r));
          tx_end();
          m_goto(r, 0);
        end
        5: begin
          tx_begin();
          send_byte(8'h1B);
          send_byte(8'($urandom_range(8'h41, 8'h5A)));
          tx_end();
          m_err++;
        end
        default: tx_clear();
      endcase
      check_all($sformatf("rand%0d", it));
    end

    // Reset three bits into a byte.
    c = 0;
    tx_begin();
    spi_bits(8'hFF, 3);
    rstn = 1'b0;
    wait_clk(3);
    spi_if.ei_csn = 1'b1;
    spi_if.ei_sck = 1'b0;
    wait_clk(2);
    rstn = 1'b1;
    m_reset();
    exp_q.delete();
    wait_clk(SYNC + 6);
    check_reset_vals("mid_reset");
    s = "B";
    tx_text(s);
    `CHK("after_reset_byte", o_byte_data, 8'h42)
    check_all("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
